sopc_bus_arbiter: RTL

Two-master, one-slave bus arbiter for the minimal SOPC. It shares the single system bus, which carries the unified RAM and the seg/led/sw/btn peripheral registers, between the OpenMIPS instruction-fetch port (M0) and data port (M1). It serializes their accesses, stalls the losing master, and recovers from a non-responding slave with a watchdog.

---
 rtl/sopc_bus_pkg.sv | 11 +
 rtl/sopc_bus_arbiter_if.sv | 42 ++++
 rtl/sopc_bus_watchdog.sv | 25 ++
 rtl/sopc_bus_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sopc_bus_pkg.sv
// Shared types and widths for the SOPC two-master system bus.
package sopc_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_e;
endpackage

// File: rtl/sopc_bus_arbiter_if.sv
// Signal bundle for the SOPC bus: two master ports plus the shared slave port.
interface sopc_bus_arbiter_if;
    import sopc_bus_pkg::*;

    logic              m0_req,   m1_req;
    logic [ADDR_W-1:0] m0_addr,  m1_addr;
    logic              m0_we,    m1_we;
    logic [SEL_W-1:0]  m0_sel,   m1_sel;
    logic [DATA_W-1:0] m0_wdata, m1_wdata;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic              m0_ack,   m1_ack;
    logic              m0_err,   m1_err;
    logic              m0_stall, m1_stall;

    logic              s_stb;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [SEL_W-1:0]  s_sel;
    logic [DATA_W-1:0] s_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_ack;

    // master: the arbiter, which masters the shared slave bus
    modport master (
        input  m0_req, m0_addr, m0_we, m0_sel, m0_wdata,
        input  m1_req, m1_addr, m1_we, m1_sel, m1_wdata,
        output m0_rdata, m0_ack, m0_err, m0_stall,
        output m1_rdata, m1_ack, m1_err, m1_stall,
        output s_stb, s_addr, s_we, s_sel, s_wdata,
        input  s_rdata, s_ack
    );

    // slave: the surrounding system (CPU ports and the addressed slave)
    modport slave (
        output m0_req, m0_addr, m0_we, m0_sel, m0_wdata,
        output m1_req, m1_addr, m1_we, m1_sel, m1_wdata,
        input  m0_rdata, m0_ack, m0_err, m0_stall,
        input  m1_rdata, m1_ack, m1_err, m1_stall,
        input  s_stb, s_addr, s_we, s_sel, s_wdata,
        output s_rdata, s_ack
    );
endinterface

// File: rtl/sopc_bus_watchdog.sv
// Saturating no-ack counter; expired holds once TIMEOUT unacked strobe cycles are seen.
module sopc_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    assign expired = (cnt == W'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sopc_bus_arbiter.sv
// Round-robin arbiter sharing one slave between the instruction and data ports,
// with a watchdog that turns a silent slave into an error completion.
module sopc_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sopc_bus_arbiter_if.master        bus
);
    import sopc_bus_pkg::*;

    state_e                  state_q, state_nx;
    logic                    last_q, last_nx;
    logic                    drop_q, drop_nx;
    logic                    stb_q, stb_nx;
    logic [ADDR_W-1:0]       addr_q, addr_nx;
    logic                    we_q, we_nx;
    logic [SEL_W-1:0]        sel_q, sel_nx;
    logic [DATA_W-1:0]       wdata_q, wdata_nx;
    logic [1:0]              ack_q, ack_nx;
    logic [1:0]              err_q, err_nx;
    logic [1:0][DATA_W-1:0]  rdata_q, rdata_nx;

    logic [1:0]              req;
    logic [1:0][ADDR_W-1:0]  m_addr;
    logic [1:0]              m_we;
    logic [1:0][SEL_W-1:0]   m_sel;
    logic [1:0][DATA_W-1:0]  m_wdata;
    logic                    gnt, cur, keep;
    logic                    wd_clr, wd_exp;

    assign req     = {bus.m1_req,   bus.m0_req};
    assign m_addr  = {bus.m1_addr,  bus.m0_addr};
    assign m_we    = {bus.m1_we,    bus.m0_we};
    assign m_sel   = {bus.m1_sel,   bus.m0_sel};
    assign m_wdata = {bus.m1_wdata, bus.m0_wdata};

    sopc_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .en      (stb_q & ~bus.s_ack),
        .expired (wd_exp)
    );

    always_comb begin
        state_nx = state_q;
        last_nx  = last_q;
        drop_nx  = drop_q;
        stb_nx   = stb_q;
        addr_nx  = addr_q;
        we_nx    = we_q;
        sel_nx   = sel_q;
        wdata_nx = wdata_q;
        ack_nx   = '0;
        err_nx   = '0;
        rdata_nx = rdata_q;
        wd_clr   = 1'b0;
        gnt      = M0;
        cur      = (state_q == BUSY1);
        // a master that let go at any point during its slot gets no completion
        keep     = ~drop_q & req[cur];

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt      = (&req) ? ~last_q : req[M1];
                    stb_nx   = 1'b1;
                    addr_nx  = m_addr[gnt];
                    we_nx    = m_we[gnt];
                    sel_nx   = m_sel[gnt];
                    wdata_nx = m_wdata[gnt];
                    wd_clr   = 1'b1;
                    drop_nx  = 1'b0;
                    state_nx = gnt ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (!req[cur])
                    drop_nx = 1'b1;
                if (bus.s_ack) begin
                    stb_nx      = 1'b0;
                    ack_nx[cur] = keep;
                    if (keep && !we_q)
                        rdata_nx[cur] = bus.s_rdata;
                    last_nx     = cur;
                    state_nx    = IDLE;
                end else if (wd_exp) begin
                    stb_nx      = 1'b0;
                    ack_nx[cur] = keep;
                    err_nx[cur] = keep;
                    if (keep)
                        rdata_nx[cur] = '0;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= M0;
            drop_q  <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_nx;
            last_q  <= last_nx;
            drop_q  <= drop_nx;
            stb_q   <= stb_nx;
            addr_q  <= addr_nx;
            we_q    <= we_nx;
            sel_q   <= sel_nx;
            wdata_q <= wdata_nx;
            ack_q   <= ack_nx;
            err_q   <= err_nx;
            rdata_q <= rdata_nx;
        end
    end

    assign bus.s_stb    = stb_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_we     = we_q;
    assign bus.s_sel    = sel_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = rdata_q[0];
    assign bus.m1_rdata = rdata_q[1];
    assign bus.m0_stall = bus.m0_req & ~ack_q[0];
    assign bus.m1_stall = bus.m1_req & ~ack_q[1];
endmodule
